// File: rtl/taskwait_requester.sv
// Taskwait requester: sends a two-beat taskwait request (header, parent task id)
// to the taskwait manager and waits for a wakeup. Optional watchdog: TW_TIMEOUT_EN.
module taskwait_requester #(
  parameter int ACC_BITS       = 4,
  parameter int ACC_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_components,
  input  logic [63:0]         req_ptid,
  output logic                done,
  output logic                busy,
  output logic                error,
  output logic [63:0]         outStream_TDATA,
  output logic                outStream_TVALID,
  input  logic                outStream_TREADY,
  output logic [ACC_BITS-1:0] outStream_TID,
  input  logic [63:0]         inStream_TDATA,
  input  logic                inStream_TVALID,
  output logic                inStream_TREADY
);

  // OmpSsManager header layout for a taskwait request.
  localparam int INSTREAM_COMPONENTS_L = 32;
  localparam int INSTREAM_COMPONENTS_H = 63;
  localparam int TYPE_B                = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HEADER,
    ST_SEND_PTID,
    ST_WAIT_WAKEUP,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] ptid_q;
  logic [63:0] tdata_q;
  logic [63:0] header;
  logic        req_fire;
  logic        out_fire;
  logic        wake_fire;
  logic        timeout_hit;

  assign req_fire  = req_valid && req_ready;
  assign out_fire  = outStream_TVALID && outStream_TREADY;
  assign wake_fire = inStream_TVALID && inStream_TREADY;

  // Only the wakeup flag bit of the incoming beat carries meaning.
  logic unused_in_bits;
  assign unused_in_bits = ^inStream_TDATA[63:1];

  always_comb begin
    header = '0;
    header[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = req_components;
    header[TYPE_B] = 1'b1;
  end

`ifdef TW_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        error_q;

  assign timeout_hit = (state_q == ST_WAIT_WAKEUP) &&
                       (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (state_q != ST_WAIT_WAKEUP && state_d == ST_WAIT_WAKEUP)
        wait_cnt_q <= '0;
      else if (state_q == ST_WAIT_WAKEUP)
        wait_cnt_q <= wait_cnt_q + 32'd1;
      // A real wakeup in the same cycle wins; error only flags a true expiry.
      if (timeout_hit && !(wake_fire && inStream_TDATA[0]))
        error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire)
          state_d = (req_components != 32'd0) ? ST_SEND_HEADER : ST_DONE;
      end
      ST_SEND_HEADER: if (out_fire) state_d = ST_SEND_PTID;
      ST_SEND_PTID:   if (out_fire) state_d = ST_WAIT_WAKEUP;
      ST_WAIT_WAKEUP: begin
        if ((wake_fire && inStream_TDATA[0]) || timeout_hit)
          state_d = ST_DONE;
      end
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers carry no reset; TVALID, derived from the reset
  // state, is what qualifies them.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      ptid_q  <= req_ptid;
      tdata_q <= header;
    end else if (state_q == ST_SEND_HEADER && out_fire) begin
      tdata_q <= ptid_q;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign outStream_TVALID = (state_q == ST_SEND_HEADER) || (state_q == ST_SEND_PTID);
  assign outStream_TDATA  = tdata_q;
  assign outStream_TID    = ACC_BITS'(ACC_ID);
  assign inStream_TREADY  = (state_q == ST_WAIT_WAKEUP);

endmodule

// File: tb/tb_taskwait_requester.sv
// Self-checking bench for taskwait_requester: vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_taskwait_requester;

  localparam int ACC_BITS = 4;
  localparam int ACC_ID   = 5;
`ifdef TW_TIMEOUT_EN
  localparam int TIMEOUT  = 16;
`else
  localparam int TIMEOUT  = 1048576;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_components;
  logic [63:0]         req_ptid;
  logic                done;
  logic                busy;
  logic                error;
  logic [63:0]         out_tdata;
  logic                out_tvalid;
  logic                out_tready;
  logic [ACC_BITS-1:0] out_tid;
  logic [63:0]         in_tdata;
  logic                in_tvalid;
  logic                in_tready;

  int n_cmp  = 0;
  int n_fail = 0;

  taskwait_requester #(
    .ACC_BITS(ACC_BITS), .ACC_ID(ACC_ID), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_components(req_components), .req_ptid(req_ptid),
    .done(done), .busy(busy), .error(error),
    .outStream_TDATA(out_tdata), .outStream_TVALID(out_tvalid),
    .outStream_TREADY(out_tready), .outStream_TID(out_tid),
    .inStream_TDATA(in_tdata), .inStream_TVALID(in_tvalid),
    .inStream_TREADY(in_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [31:0] comp;
    logic [63:0] ptid;
    int          stall_hdr;
    int          stall_ptid;
    int          n_disc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Header word as the manager expects it: components in [63:32], type bit 1.
  function automatic logic [63:0] model_header(input logic [31:0] comp);
    return ({32'h0, comp} << 32) | (64'd1 << 1);
  endfunction

  task automatic send_beat(input string name, input logic [63:0] exp, input int stall);
    out_tready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check({name, "_stall_valid"}, 64'(out_tvalid), 64'd1);
      check({name, "_stall_data"}, out_tdata, exp);
      step();
    end
    check({name, "_valid"}, 64'(out_tvalid), 64'd1);
    check({name, "_data"}, out_tdata, exp);
    check({name, "_tid"}, 64'(out_tid), 64'(ACC_ID));
    check({name, "_in_ready"}, 64'(in_tready), 64'd0);
    out_tready = 1'b1;
    step();
    out_tready = 1'b0;
  endtask

  task automatic start_req(input logic [31:0] comp, input logic [63:0] ptid);
    req_valid      = 1'b1;
    req_components = comp;
    req_ptid       = ptid;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_wake(input int n_disc);
    check("wait_tvalid", 64'(out_tvalid), 64'd0);
    check("wait_in_ready", 64'(in_tready), 64'd1);
    for (int i = 0; i < n_disc; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = {$urandom, $urandom} & ~64'd1;
      step();
      check("discard_no_done", 64'(done), 64'd0);
      check("discard_in_ready", 64'(in_tready), 64'd1);
    end
    in_tvalid = 1'b1;
    in_tdata  = {$urandom, $urandom} | 64'd1;
    step();
    in_tvalid = 1'b0;
    check("wake_done", 64'(done), 64'd1);
    check("wake_busy", 64'(busy), 64'd1);
    check("wake_error", 64'(error), 64'd0);
    step();
    check("after_done", 64'(done), 64'd0);
    check("after_busy", 64'(busy), 64'd0);
    check("after_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic run_txn(input logic [31:0] comp, input logic [63:0] ptid,
                         input int stall_hdr, input int stall_ptid, input int n_disc);
    start_req(comp, ptid);
    if (comp == 32'd0) begin
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd1);
      check("zero_tvalid", 64'(out_tvalid), 64'd0);
      step();
      check("zero_done_end", 64'(done), 64'd0);
      check("zero_busy_end", 64'(busy), 64'd0);
      check("zero_ready", 64'(req_ready), 64'd1);
      return;
    end
    send_beat("hdr", model_header(comp), stall_hdr);
    send_beat("ptid", ptid, stall_ptid);
    finish_wake(n_disc);
  endtask

  vec_t vecs[5];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_components = '0; req_ptid = '0;
    out_tready = 1'b0; in_tvalid = 1'b0; in_tdata = '0;
    step(); step();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_in_ready", 64'(in_tready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    step();

    vecs[0] = '{32'd3, 64'h0000_0001_0000_00AB, 0, 0, 0};
    vecs[1] = '{32'd0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0};
    vecs[2] = '{32'd7, 64'hDEAD_BEEF_0000_0042, 5, 0, 0};
    vecs[3] = '{32'd1, 64'h0000_0000_0000_0001, 0, 0, 1};
    vecs[4] = '{32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 2};
    foreach (vecs[i])
      run_txn(vecs[i].comp, vecs[i].ptid, vecs[i].stall_hdr, vecs[i].stall_ptid, vecs[i].n_disc);

    // Request held off while busy, ptid latched, early wakeup left pending.
    req_valid = 1'b1; req_components = 32'd2; req_ptid = 64'hAAAA_0000_0000_0002;
    out_tready = 1'b1; in_tvalid = 1'b1; in_tdata = 64'd1;
    check("ho_ready0", 64'(req_ready), 64'd1);
    step();
    check("ho_hdr", out_tdata, model_header(32'd2));
    check("ho_in_ready_hdr", 64'(in_tready), 64'd0);
    check("ho_ready_busy", 64'(req_ready), 64'd0);
    req_components = 32'd9; req_ptid = 64'hBBBB_0000_0000_0009;
    step();
    check("ho_ptid_latched", out_tdata, 64'hAAAA_0000_0000_0002);
    check("ho_in_ready_ptid", 64'(in_tready), 64'd0);
    step();
    check("ho_wait_in_ready", 64'(in_tready), 64'd1);
    step();
    in_tvalid = 1'b0;
    check("ho_done", 64'(done), 64'd1);
    check("ho_ready_done", 64'(req_ready), 64'd0);
    step();
    check("ho_idle_ready", 64'(req_ready), 64'd1);
    check("ho_idle_done", 64'(done), 64'd0);
    step();
    req_valid = 1'b0;
    check("ho_second_hdr", out_tdata, model_header(32'd9));
    step();
    check("ho_second_ptid", out_tdata, 64'hBBBB_0000_0000_0009);
    step();
    out_tready = 1'b0;
    finish_wake(0);

    // Reset during the ptid beat aborts the transaction.
    out_tready = 1'b1;
    start_req(32'd4, 64'h0000_0000_CAFE_0004);
    step();
    check("ar_in_ptid", 64'(out_tvalid), 64'd1);
    out_tready = 1'b0;
    rst = 1'b1;
    #1;
    check("ar_tvalid", 64'(out_tvalid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_ready", 64'(req_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    check("ar_no_beat", 64'(out_tvalid), 64'd0);
    run_txn(32'd4, 64'h0000_0000_CAFE_0005, 0, 1, 0);

    // Randomized transactions against the model.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] c;
      c = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_txn(c, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2));
    end

`ifdef TW_TIMEOUT_EN
    start_req(32'd1, 64'd77);
    send_beat("to_hdr", model_header(32'd1), 0);
    send_beat("to_ptid", 64'd77, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      check("to_no_done", 64'(done), 64'd0);
    end
    step();
    check("to_done", 64'(done), 64'd1);
    check("to_error", 64'(error), 64'd1);
    step();
    step();
    check("to_done_end", 64'(done), 64'd0);
    check("to_error_sticky", 64'(error), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("to_error_cleared", 64'(error), 64'd0);
    step();
`else
    start_req(32'd1, 64'd77);
    send_beat("nt_hdr", model_header(32'd1), 0);
    send_beat("nt_ptid", 64'd77, 0);
    repeat (40) step();
    check("nt_no_done", 64'(done), 64'd0);
    check("nt_busy", 64'(busy), 64'd1);
    check("nt_error", 64'(error), 64'd0);
    finish_wake(0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/taskwait_requester.md
TASKWAIT_REQUESTER -- requirements
Module: taskwait_requester

Interface
REQ-001 Parameter ACC_BITS, default 4: width of the accelerator identifier.
REQ-002 Parameter ACC_ID, default 0: this accelerator's identifier, driven on outStream_TID.
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576: wakeup watchdog limit; used only under TW_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; asynchronous assertion, active-high.
REQ-006 req_valid  input  1  accelerator requests a taskwait.
REQ-007 req_ready  output  1  request accepted when high together with req_valid.
REQ-008 req_components  input  32  number of child tasks to wait for.
REQ-009 req_ptid  input  64  parent task identifier word.
REQ-010 done  output  1  one-cycle pulse: taskwait completed.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 error  output  1  sticky watchdog flag.
REQ-013 outStream_TDATA/TVALID/TREADY/TID  output/output/input/output  64/1/1/ACC_BITS  request stream toward the taskwait manager.
REQ-014 inStream_TDATA/TVALID/TREADY  input/input/output  64/1/1  wakeup stream from the taskwait manager.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND_HEADER, SEND_PTID, WAIT_WAKEUP and DONE.
REQ-016 req_ready SHALL be high only in IDLE; a request handshake in cycle T SHALL latch req_components and req_ptid.
REQ-017 After a handshake with req_components != 0, the FSM SHALL enter SEND_HEADER, so that outStream_TVALID is high from T+1.
REQ-018 After a handshake with req_components == 0, the FSM SHALL go directly to DONE, with no stream traffic; done SHALL pulse in T+1.
REQ-019 The header beat in SEND_HEADER SHALL carry:
- OmpSsManager field [INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = latched components;
- bit TYPE_B = 1;
- all other bits = 0.
REQ-020 The second beat in SEND_PTID SHALL carry the latched req_ptid.
REQ-021 outStream_TID SHALL equal ACC_ID on both beats.
REQ-022 outStream_TVALID SHALL be high only in SEND_HEADER and SEND_PTID.
REQ-023 outStream_TDATA SHALL be registered and held stable while TVALID is high and TREADY is low.
REQ-024 Each beat SHALL advance the FSM only on TVALID && TREADY: SEND_HEADER to SEND_PTID, then SEND_PTID to WAIT_WAKEUP.
REQ-025 inStream_TREADY SHALL be high only in WAIT_WAKEUP; beats offered in any other state SHALL be left pending.
REQ-026 In WAIT_WAKEUP, an accepted beat with TDATA[0] = 1 SHALL move the FSM to DONE; an accepted beat with TDATA[0] = 0 SHALL be discarded and the FSM SHALL stay in WAIT_WAKEUP.
REQ-027 DONE SHALL last exactly one cycle with done = 1, then return to IDLE; back-to-back requests SHALL therefore be separated by at least one IDLE cycle.
REQ-028 A new request presented during busy SHALL be held off (req_ready = 0) and not lost.

Reset
REQ-029 While rst = 1, the FSM SHALL be in IDLE with req_ready = 1 and with outStream_TVALID, inStream_TREADY, done, busy and error all 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no further beats emitted; a partially sent request is not retried.

Configuration
REQ-031 With macro TW_TIMEOUT_EN defined:
- a 32-bit counter SHALL clear on entry to WAIT_WAKEUP and increment every cycle in that state;
- on reaching TIMEOUT_CYCLES, error SHALL set (sticky until rst) and the FSM SHALL go to DONE, pulsing done.
REQ-032 Without TW_TIMEOUT_EN, error SHALL be constant 0, no counter SHALL exist, and WAIT_WAKEUP SHALL wait indefinitely.

Verification
REQ-033 Request with components = 3 and ptid = 0x0000_0001_0000_00AB, TREADY held 1 -> header beat with components = 3 and TYPE_B = 1, then ptid beat, TID = ACC_ID; wakeup TDATA = 1 -> done pulses one cycle later.
REQ-034 Request with components = 0 -> no outStream beats; done pulses in T+1; busy high for exactly one cycle.
REQ-035 TREADY low for 5 cycles during the header beat -> TDATA and TVALID remain stable, and the ptid beat follows the first ready cycle.
REQ-036 Wakeup beat TDATA = 0 followed by TDATA = 1 -> first beat discarded with no done; done follows the second beat.
REQ-037 rst pulsed while in SEND_PTID -> TVALID drops immediately, the FSM is in IDLE, and the next request is sent in full.
REQ-038 With TW_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no wakeup -> error = 1 and done pulses 16 cycles after entering WAIT_WAKEUP; error stays 1 until rst.
